// File: rtl/or8b_pkg.sv
// -----------------------------------------------------------------------------
// or8b_pkg
// Shared constants for the 8-bit logic-operator family. Only the default
// datapath width lives here, so the sibling operators stay in step with it.
// -----------------------------------------------------------------------------
package or8b_pkg;

   localparam int OR8B_WIDTH = 8;

endpackage : or8b_pkg

// File: rtl/or8b_or1b.sv
// -----------------------------------------------------------------------------
// or1b
// Single-bit combinational OR cell. or8b replicates it once per result bit.
//
// Ports:
//   a - operand bit A
//   b - operand bit B
//   f - a | b
// -----------------------------------------------------------------------------
module or1b (
   input  logic a,
   input  logic b,
   output logic f
);

   assign f = a | b;

endmodule : or1b

// File: rtl/or8b.sv
// -----------------------------------------------------------------------------
// or8b
// Registered bitwise OR unit. An operand pair accepted with in_valid appears one
// clock later on F, together with out_valid and the all-zero / all-one flags.
// A cycle without in_valid keeps F and the flags and drops out_valid.
//
// Parameters:
//   WIDTH     - operand/result width in bits (>= 1)
//
// Ports:
//   clk       - clock, rising edge active
//   rst       - asynchronous, active-high reset
//   F         - registered result A | B
//   A, B      - operands
//   in_valid  - operand pair is valid this cycle
//   out_valid - F and the flags hold a fresh result
//   zero      - registered result is all zeros
//   ones      - registered result is all ones
// -----------------------------------------------------------------------------
module or8b
   import or8b_pkg::*;
#(
   parameter int WIDTH = OR8B_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] F,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             in_valid,
   output logic             out_valid,
   output logic             zero,
   output logic             ones
);

   logic [WIDTH-1:0] w_or;
   logic             w_zero;
   logic             w_ones;

   logic [WIDTH-1:0] r_f;
   logic             r_valid;
   logic             r_zero;
   logic             r_ones;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      or1b u_or1b (
         .a (A[g]),
         .b (B[g]),
         .f (w_or[g])
      );
   end

   // Flags are taken from the combinational OR vector and registered together
   // with it, so they are always aligned with the F they describe.
   assign w_zero = ~|w_or;
   assign w_ones = &w_or;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_f     <= '0;
         r_valid <= 1'b0;
         r_zero  <= 1'b1;   // reset result is 0, so the zero flag is set
         r_ones  <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_f    <= w_or;
            r_zero <= w_zero;
            r_ones <= w_ones;
         end
      end
   end

   assign F         = r_f;
   assign out_valid = r_valid;
   assign zero      = r_zero;
   assign ones      = r_ones;

endmodule : or8b

// File: tb/tb_or8b.sv
// -----------------------------------------------------------------------------
// tb_or8b
// Directed, table-driven bench for or8b (default width) plus a WIDTH=1 copy
// driven from bit 0 of the same operands.
// -----------------------------------------------------------------------------
module tb_or8b;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       valid;
      logic [7:0] exp_f;
      logic       exp_valid;
      logic       exp_zero;
      logic       exp_ones;
   } vec_t;

   localparam int N_VEC = 12;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic       in_valid;
   logic [7:0] f;
   logic       out_valid;
   logic       zero;
   logic       ones;

   logic [0:0] a1;
   logic [0:0] b1;
   logic [0:0] f1;
   logic       out_valid1;
   logic       zero1;
   logic       ones1;

   int n_checks;
   int n_fail;

   vec_t vecs [N_VEC];

   assign a1 = a[0:0];
   assign b1 = b[0:0];

   or8b u_dut (
      .clk       (clk),
      .rst       (rst),
      .F         (f),
      .A         (a),
      .B         (b),
      .in_valid  (in_valid),
      .out_valid (out_valid),
      .zero      (zero),
      .ones      (ones)
   );

   or8b #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .F         (f1),
      .A         (a1),
      .B         (b1),
      .in_valid  (in_valid),
      .out_valid (out_valid1),
      .zero      (zero1),
      .ones      (ones1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [7:0] ef, input logic ev,
                                input logic ez, input logic eo);
      check({tag, " F"},         f,         ef);
      check({tag, " out_valid"}, out_valid, {7'd0, ev});
      check({tag, " zero"},      zero,      {7'd0, ez});
      check({tag, " ones"},      ones,      {7'd0, eo});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      //                 a       b      vld  F      ov    zero  ones
      vecs[0]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};  // all-zero operands
      vecs[1]  = '{8'h0F, 8'hF0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1};  // disjoint nibbles
      vecs[2]  = '{8'hAA, 8'h55, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1};  // back-to-back #1
      vecs[3]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1};  // back-to-back #2
      vecs[4]  = '{8'h0F, 8'h30, 1'b1, 8'h3F, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{8'hFF, 8'hFF, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0};  // hold, valid drops
      vecs[6]  = '{8'h12, 8'h40, 1'b1, 8'h52, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{8'hxx, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1};  // a 1 dominates unknowns
      vecs[8]  = '{8'h80, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1};  // hold all-ones result
      vecs[9]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};  // zero after nonzero
      vecs[10] = '{8'h01, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};  // LSB only
      vecs[11] = '{8'h7F, 8'h80, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1};  // MSB completes all-ones

      a        = 8'h00;
      b        = 8'h00;
      in_valid = 1'b0;
      rst      = 1'b0;

      // Asynchronous reset assertion away from any clock edge.
      #2 rst = 1'b1;
      #1;
      check_outputs("reset", 8'h00, 1'b0, 1'b1, 1'b0);
      check("reset w1 F",    {7'd0, f1},    8'h00);
      check("reset w1 zero", {7'd0, zero1}, 8'h01);
      check("reset w1 ones", {7'd0, ones1}, 8'h00);

      // Inputs are ignored while reset is held.
      a        = 8'hFF;
      b        = 8'hFF;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check_outputs("reset held", 8'h00, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;

      for (int i = 0; i < N_VEC; i++) begin
         @(negedge clk);
         a        = vecs[i].a;
         b        = vecs[i].b;
         in_valid = vecs[i].valid;
         @(posedge clk); #1;
         check_outputs($sformatf("vec%0d", i), vecs[i].exp_f, vecs[i].exp_valid,
                       vecs[i].exp_zero, vecs[i].exp_ones);
         // WIDTH=1 copy sees bit 0 of the operands; zero and ones are complements.
         check($sformatf("vec%0d w1 F", i),    {7'd0, f1},    {7'd0, vecs[i].exp_f[0]});
         check($sformatf("vec%0d w1 zero", i), {7'd0, zero1}, {7'd0, ~vecs[i].exp_f[0]});
         check($sformatf("vec%0d w1 ones", i), {7'd0, ones1}, {7'd0, vecs[i].exp_f[0]});
      end

      // Reset mid-stream: 0x81 is presented but reset lands before its edge.
      @(negedge clk);
      a        = 8'h81;
      b        = 8'h00;
      in_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      check_outputs("midreset async", 8'h00, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      check_outputs("midreset edge", 8'h00, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check_outputs($sformatf("post-reset c%0d", c), 8'h00, 1'b0, 1'b1, 1'b0);
      end

      // The block accepts again after reset release.
      @(negedge clk);
      a        = 8'h81;
      b        = 8'h00;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check_outputs("recover", 8'h81, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check_outputs("recover hold", 8'h81, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_or8b
